mem_port_arbiter: RTL

//  Shares one single-port, byte-writable SRAM between instruction fetch (IFU) and load/store (LSU).

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_starve_cnt.sv | 38 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
// No logic; latency and backpressure are defined by the users of this package.
// The range check is shared so that grant and response paths agree on what is out of range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RSP_IFU = 2'd1,
        RSP_LSU = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [31:0] NOP_INS   = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [32:0] limit);
        return ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// IFU starvation counter: counts IFU losses to the LSU, saturating at MAX_WAIT.
// fire_o is registered state, valid the cycle the count reaches MAX_WAIT; no backpressure.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic fire_o
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != WAIT_LIM)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire_o = (cnt_q == WAIT_LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-writable SRAM between IFU and LSU, LSU first (IFU guard: MEM_ARB_STARVE_GUARD_EN).
// Grant is combinational; read data / error response one cycle after the grant.
// Losing requester is held by withholding its grant; one access per cycle, no internal buffering.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 65536,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_err_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_sel_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    logic       ifu_in_range;
    logic       lsu_in_range;
    logic       guard_fire;
    logic       ifu_gnt;
    logic       lsu_gnt;
    mem_req_t   mem_req;
    rsp_state_e state_q;
    rsp_state_e state_d;
    logic       err_q;
    logic       err_d;

    assign ifu_in_range = addr_in_range(ifu_addr_i, MEM_LIMIT);
    assign lsu_in_range = addr_in_range(lsu_addr_i, MEM_LIMIT);

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .inc_i   (ifu_req_i & lsu_gnt),
        .clr_i   (ifu_gnt),
        .fire_o  (guard_fire)
    );
`else
    assign guard_fire = 1'b0;
`endif

    // Grants are gated by reset so the memory is never driven while the core is held in reset.
    assign ifu_gnt = n_rst_i & ifu_req_i & (~lsu_req_i | guard_fire);
    assign lsu_gnt = n_rst_i & lsu_req_i & ~ifu_gnt;

    assign ifu_gnt_o = ifu_gnt;
    assign lsu_gnt_o = lsu_gnt;

    always_comb begin
        mem_req = '0;
        if (lsu_gnt && lsu_in_range) begin
            mem_req.ce    = 1'b1;
            mem_req.we    = lsu_we_i;
            mem_req.sel   = lsu_we_i ? lsu_sel_i : 4'hF;
            mem_req.addr  = {lsu_addr_i[31:2], 2'b00};
            mem_req.wdata = lsu_wdata_i;
        end else if (ifu_gnt && ifu_in_range) begin
            mem_req.ce    = 1'b1;
            mem_req.sel   = 4'hF;
            mem_req.addr  = {ifu_addr_i[31:2], 2'b00};
        end
    end

    assign mem_ce_o    = mem_req.ce;
    assign mem_we_o    = mem_req.we;
    assign mem_sel_o   = mem_req.sel;
    assign mem_addr_o  = mem_req.addr;
    assign mem_wdata_o = mem_req.wdata;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // In-range stores retire at the grant; everything else owes exactly one response.
    always_comb begin
        state_d      = IDLE;
        err_d        = 1'b0;
        ifu_rvalid_o = 1'b0;
        ifu_err_o    = 1'b0;
        ifu_rdata_o  = NOP_INS;
        lsu_rvalid_o = 1'b0;
        lsu_err_o    = 1'b0;
        lsu_rdata_o  = ZERO_WORD;

        if (ifu_gnt) begin
            state_d = RSP_IFU;
            err_d   = ~ifu_in_range;
        end else if (lsu_gnt && (!lsu_we_i || !lsu_in_range)) begin
            state_d = RSP_LSU;
            err_d   = ~lsu_in_range;
        end

        case (state_q)
            RSP_IFU: begin
                ifu_rvalid_o = 1'b1;
                ifu_err_o    = err_q;
                ifu_rdata_o  = err_q ? NOP_INS : mem_rdata_i;
            end
            RSP_LSU: begin
                lsu_rvalid_o = 1'b1;
                lsu_err_o    = err_q;
                lsu_rdata_o  = err_q ? ZERO_WORD : mem_rdata_i;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    ifu_req_held_a: assert property (@(posedge clk_i) disable iff (!n_rst_i)
        (ifu_req_i && !ifu_gnt) |=> ifu_req_i);
    lsu_req_held_a: assert property (@(posedge clk_i) disable iff (!n_rst_i)
        (lsu_req_i && !lsu_gnt) |=> lsu_req_i);
    params_ok_a: assert property (@(posedge clk_i)
        (MAX_WAIT >= 1) && (MAX_WAIT <= 15) && ((MEM_BYTES & (MEM_BYTES - 1)) == 0));
`endif

endmodule
